// File: rtl/rv32i_types.sv
// Shared RV32I types: load/store funct3 encodings and the LSU state encoding.
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } lsu_state_t;

  // Exactly one of load/store must be set and funct3 must be a defined encoding for that kind.
  function automatic logic f3_legal(input logic ld, input logic st, input logic [2:0] f3);
    if (ld == st) return 1'b0;
    if (ld) return f3 inside {LB, LH, LW, LBU, LHU};
    return f3 inside {SB, SH, SW};
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response and data-memory bus bundle of the load/store unit.
interface dmem_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_load;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [4:0]            req_rd;
  logic                  flush;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic [4:0]            rsp_rd;
  logic                  rsp_err;
  logic                  dmem_read;
  logic                  dmem_write;
  logic [ADDR_WIDTH-1:0] dmem_address;
  logic [3:0]            dmem_byte_enable;
  logic [31:0]           dmem_wdata;
  logic [31:0]           dmem_rdata;
  logic                  dmem_resp;

  // slave: the LSU itself; master: the pipeline plus data memory around it
  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd, flush,
    input  dmem_rdata, dmem_resp,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
    output dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata
  );

  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd, flush,
    output dmem_rdata, dmem_resp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
    input  dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: two-beat strobe mask, per-beat store shift, load merge and extension.
module lsu_lane_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_beat0,
  input  logic [31:0] ld_beat1,
  output logic [7:0]  wide,
  output logic [31:0] st_data0,
  output logic [31:0] st_data1,
  output logic [31:0] ld_data
);
  logic [3:0]  mask;
  logic [5:0]  sh1;
  logic [31:0] merged;

  always_comb begin
    case (funct3[1:0])
      2'b00:   mask = 4'h1;
      2'b01:   mask = 4'h3;
      2'b10:   mask = 4'hF;
      default: mask = 4'h0;
    endcase
    wide     = {4'b0000, mask} << off;
    st_data0 = st_data << {off, 3'b000};
    // off==0 gives a 32-bit shift, which clears the (unused) second beat
    sh1      = 6'd32 - {1'b0, off, 3'b000};
    st_data1 = st_data >> sh1;
    merged   = 32'({ld_beat1, ld_beat0} >> {off, 3'b000});
    case (funct3)
      LB:      ld_data = {{24{merged[7]}}, merged[7:0]};
      LH:      ld_data = {{16{merged[15]}}, merged[15:0]};
      LBU:     ld_data = {24'h0, merged[7:0]};
      LHU:     ld_data = {16'h0, merged[15:0]};
      default: ld_data = merged;
    endcase
  end
endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: request capture, one- or two-beat bus FSM, watchdog and result return.
module dmem_lsu
  import rv32i_types::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int SPLIT_MISALIGNED = 1,
  parameter int MAX_WAIT         = 255
) (
  input logic       clk,
  input logic       rst_n,
  dmem_lsu_if.slave bus
);
  localparam int WD_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  lsu_state_t            state_q, state_d;
  logic                  is_load_q, is_load_d, mis_q, mis_d, squash_q, squash_d, err_q, err_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           st_data_q, st_data_d, beat0_q, beat0_d, rdata_q, rdata_d;
  logic [4:0]            rd_q, rd_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic                  read_q, read_d, write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;

  logic        sel_req, misaligned, legal;
  logic [7:0]  wide;
  logic [31:0] st_data0, st_data1, ld_data;

  // In IDLE the aligner decodes the incoming request; afterwards it works on the captured one.
  assign sel_req = (state_q == IDLE);

  lsu_lane_align u_align (
    .funct3   (sel_req ? bus.req_funct3 : funct3_q),
    .off      (sel_req ? bus.req_addr[1:0] : off_q),
    .st_data  (sel_req ? bus.req_wdata : st_data_q),
    .ld_beat0 ((state_q == BEAT0) ? bus.dmem_rdata : beat0_q),
    .ld_beat1 (bus.dmem_rdata),
    .wide     (wide),
    .st_data0 (st_data0),
    .st_data1 (st_data1),
    .ld_data  (ld_data)
  );

  assign misaligned = (wide[7:4] != 4'h0);
  assign legal      = f3_legal(bus.req_load, bus.req_store, bus.req_funct3) &&
                      !((SPLIT_MISALIGNED == 0) && misaligned);

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    mis_d     = mis_q;
    squash_d  = squash_q;
    err_d     = err_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    st_data_d = st_data_q;
    beat0_d   = beat0_q;
    rdata_d   = rdata_q;
    rd_d      = rd_q;
    wdog_d    = wdog_q;
    read_d    = read_q;
    write_d   = write_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          is_load_d = bus.req_load;
          funct3_d  = bus.req_funct3;
          off_d     = bus.req_addr[1:0];
          st_data_d = bus.req_wdata;
          rd_d      = bus.req_rd;
          mis_d     = misaligned;
          squash_d  = 1'b0;
          err_d     = 1'b0;
          rdata_d   = '0;
          wdog_d    = '0;
          if (!legal) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = BEAT0;
            read_d  = bus.req_load;
            write_d = bus.req_store;
            addr_d  = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            be_d    = wide[3:0];
            wdata_d = st_data0;
          end
        end
      end
      BEAT0, BEAT1: begin
        if (bus.flush) squash_d = 1'b1;
        if (bus.dmem_resp) begin
          wdog_d = '0;
          if ((state_q == BEAT0) && mis_q) begin
            beat0_d = bus.dmem_rdata;
            state_d = BEAT1;
            addr_d  = addr_q + ADDR_WIDTH'(4);
            be_d    = wide[7:4];
            wdata_d = st_data1;
          end else begin
            state_d = RESP;
            rdata_d = is_load_q ? ld_data : 32'h0;
            read_d  = 1'b0;
            write_d = 1'b0;
            addr_d  = '0;
            be_d    = '0;
            wdata_d = '0;
          end
        end else if ((MAX_WAIT != 0) && (wdog_q == WD_LAST)) begin
          // Abort: an already-written first beat of a split store is left in place.
          state_d = RESP;
          err_d   = 1'b1;
          read_d  = 1'b0;
          write_d = 1'b0;
          addr_d  = '0;
          be_d    = '0;
          wdata_d = '0;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_load_q <= 1'b0;
      mis_q     <= 1'b0;
      squash_q  <= 1'b0;
      err_q     <= 1'b0;
      funct3_q  <= '0;
      off_q     <= '0;
      st_data_q <= '0;
      beat0_q   <= '0;
      rdata_q   <= '0;
      rd_q      <= '0;
      wdog_q    <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      mis_q     <= mis_d;
      squash_q  <= squash_d;
      err_q     <= err_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      st_data_q <= st_data_d;
      beat0_q   <= beat0_d;
      rdata_q   <= rdata_d;
      rd_q      <= rd_d;
      wdog_q    <= wdog_d;
      read_q    <= read_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.req_ready        = (state_q == IDLE);
  assign bus.rsp_valid        = (state_q == RESP) && !squash_q && !bus.flush;
  assign bus.rsp_rdata        = (state_q == RESP) ? rdata_q : 32'h0;
  assign bus.rsp_rd           = (state_q == RESP) ? rd_q : 5'h0;
  assign bus.rsp_err          = (state_q == RESP) && err_q;
  assign bus.dmem_read        = read_q;
  assign bus.dmem_write       = write_q;
  assign bus.dmem_address     = addr_q;
  assign bus.dmem_byte_enable = be_q;
  assign bus.dmem_wdata       = wdata_q;
endmodule
